return_address_stack: RTL and testbench



---
 rtl/return_address_stack.sv | 71 +++++++
 tb/tb_return_address_stack.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/return_address_stack.sv
// return_address_stack: circular return-address stack for fetch-stage return prediction,
// with checkpoint outputs and backend restore on misprediction.
module return_address_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_en,
    input  logic [31:0]      push_addr,
    input  logic             pop_en,
    output logic [31:0]      top_addr,
    output logic             top_valid,
    output logic [PTR_W-1:0] ckpt_ptr,
    output logic [PTR_W:0]   ckpt_count,
    input  logic             recover_en,
    input  logic [PTR_W-1:0] recover_ptr,
    input  logic [PTR_W:0]   recover_count,
    input  logic             recover_top_wr,
    input  logic [31:0]      recover_top_addr,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [PTR_W:0] full_count = (PTR_W+1)'(DEPTH);

    logic [31:0]      entry [DEPTH];
    logic [PTR_W-1:0] tos_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] prev_ptr;

    assign next_ptr   = tos_ptr + 1'b1;
    assign prev_ptr   = tos_ptr - 1'b1;
    assign top_valid  = count != '0;
    assign top_addr   = top_valid ? entry[tos_ptr] : 32'd0;
    assign ckpt_ptr   = tos_ptr;
    assign ckpt_count = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= 32'd0;
            tos_ptr   <= PTR_W'(DEPTH - 1);
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (recover_en) begin
                tos_ptr <= recover_ptr;
                count   <= (recover_count > full_count) ? full_count : recover_count;
                if (recover_top_wr) entry[recover_ptr] <= recover_top_addr;
            end else if (push_en && pop_en && top_valid) begin
                // return then call: the popped slot is immediately reused
                entry[tos_ptr] <= push_addr;
            end else if (push_en) begin
                tos_ptr         <= next_ptr;
                entry[next_ptr] <= push_addr;
                if (count == full_count) overflow <= 1'b1;
                else count <= count + 1'b1;
            end else if (pop_en) begin
                if (top_valid) begin
                    tos_ptr <= prev_ptr;
                    count   <= count - 1'b1;
                end else begin
                    underflow <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: scoreboard bench; driver pushes model expectations, monitor compares after each edge.
module tb_return_address_stack;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        push_en = 1'b0, pop_en = 1'b0, recover_en = 1'b0, recover_top_wr = 1'b0;
    logic [31:0] push_addr = '0, recover_top_addr = '0;
    logic [2:0]  recover_ptr = '0;
    logic [3:0]  recover_count = '0;
    logic [31:0] top_addr;
    logic        top_valid, overflow, underflow;
    logic [2:0]  ckpt_ptr;
    logic [3:0]  ckpt_count;

    return_address_stack #(.DEPTH(D), .PTR_W(3)) dut (
        .clk(clk), .resetn(resetn), .push_en(push_en), .push_addr(push_addr), .pop_en(pop_en),
        .top_addr(top_addr), .top_valid(top_valid), .ckpt_ptr(ckpt_ptr), .ckpt_count(ckpt_count),
        .recover_en(recover_en), .recover_ptr(recover_ptr), .recover_count(recover_count),
        .recover_top_wr(recover_top_wr), .recover_top_addr(recover_top_addr),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] top;
        logic        valid;
        logic [2:0]  ptr;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [D];
    int          m_ptr, m_cnt;
    logic        m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) mem[i] = '0;
        m_ptr = D - 1;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic exp_t snap();
        exp_t s;
        s.top   = (m_cnt != 0) ? mem[m_ptr] : 32'd0;
        s.valid = m_cnt != 0;
        s.ptr   = 3'(m_ptr);
        s.cnt   = 4'(m_cnt);
        s.ovf   = m_ovf;
        s.unf   = m_unf;
        return s;
    endfunction

    // Stack semantics as arithmetic on a slot array: push goes one slot up, pop one down, count saturates at D.
    task automatic step(input bit pu, input logic [31:0] a, input bit po, input bit rc = 0,
                        input logic [2:0] rp = 0, input logic [3:0] rn = 0, input bit rw = 0,
                        input logic [31:0] ra = 0);
        @(negedge clk);
        resetn = 1'b1;
        push_en = pu; push_addr = a; pop_en = po;
        recover_en = rc; recover_ptr = rp; recover_count = rn;
        recover_top_wr = rw; recover_top_addr = ra;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (rc) begin
            m_ptr = rp;
            m_cnt = (rn > D) ? D : int'(rn);
            if (rw) mem[rp] = ra;
        end else if (pu && po && m_cnt > 0) begin
            mem[m_ptr] = a;
        end else if (pu) begin
            m_ptr = (m_ptr + 1) % D;
            mem[m_ptr] = a;
            if (m_cnt == D) m_ovf = 1'b1;
            else m_cnt++;
        end else if (po) begin
            if (m_cnt > 0) begin
                m_ptr = (m_ptr + D - 1) % D;
                m_cnt--;
            end else m_unf = 1'b1;
        end
        exp_q.push_back(snap());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_top_addr"}, top_addr, 32'd0);
        chk({tag, "_top_valid"}, 32'(top_valid), 32'd0);
        chk({tag, "_ckpt_ptr"}, 32'(ckpt_ptr), 32'd7);
        chk({tag, "_ckpt_count"}, 32'(ckpt_count), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("top_addr", top_addr, e.top);
                chk("top_valid", 32'(top_valid), 32'(e.valid));
                chk("ckpt_ptr", 32'(ckpt_ptr), 32'(e.ptr));
                chk("ckpt_count", 32'(ckpt_count), 32'(e.cnt));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("underflow", 32'(underflow), 32'(e.unf));
            end
        end
    end

    initial begin
        model_reset();
        #2 resetn = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        // basic push/pop
        step(1, 32'h100, 0); step(1, 32'h200, 0); step(1, 32'h300, 0);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        // overflow then drain to underflow
        for (int i = 1; i <= 9; i++) step(1, 32'(i * 16), 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1);
        // simultaneous push/pop, non-empty and empty
        step(1, 32'h100, 0); step(1, 32'h200, 0); step(1, 32'h555, 1);
        step(0, 0, 1); step(0, 0, 1); step(1, 32'h777, 1); step(0, 0, 1);
        // checkpoint then restore with top rewrite
        step(1, 32'h100, 0); step(1, 32'h200, 0);
        step(1, 32'hA, 0); step(0, 0, 1); step(0, 0, 1);
        step(0, 0, 0, 1, 3'd1, 4'd2, 1, 32'h200);
        // recover wins over push+pop; count clamps
        for (int i = 0; i < 8; i++) step(1, 32'h1000 + 32'(i), 0);
        step(1, 32'hDEAD, 1, 1, 3'd5, 4'd9, 0, 0);
        step(1, 32'hBEEF, 0);
        step(0, 0, 1, 1, 3'd2, 4'd0, 0, 0);
        step(0, 0, 1);
        // asynchronous reset mid-sequence
        step(1, 32'h123, 0); step(1, 32'h456, 0);
        @(negedge clk);
        push_en = 1'b0; pop_en = 1'b0; recover_en = 1'b0;
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        exp_q.push_back(snap());
        step(1, 32'h42, 0);
        // random traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 19) == 0)
                step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, 1,
                     3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 1) == 1, $urandom);
            else
                step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        push_en = 1'b0; pop_en = 1'b0; recover_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
